// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through cache with true-LRU replacement.
// Blocking line refill one word per memory handshake; no write-allocate.
module set_assoc_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 4,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG_W  = DATA_WIDTH - 2 - OFF_W - SET_W;
  localparam int LINE_W = DATA_WIDTH - 2 - OFF_W;
  localparam int DW     = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP,
    WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  valid_d [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_d   [SETS][WAYS];
  logic [WAY_W-1:0] age_q   [SETS][WAYS];
  logic [WAY_W-1:0] age_d   [SETS][WAYS];
  logic [DW-1:0]    data_q  [SETS][WAYS][WORDS_PER_LINE];
  logic [DW-1:0]    data_d  [SETS][WAYS][WORDS_PER_LINE];

  logic [OFF_W-1:0] off;
  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] tag;
  logic [SET_W-1:0] fill_set;
  logic [TAG_W-1:0] fill_tag;

  assign off      = cpu_addr[OFF_W+1:2];
  assign set_idx  = cpu_addr[SET_W+OFF_W+1:OFF_W+2];
  assign tag      = cpu_addr[DW-1:SET_W+OFF_W+2];
  assign fill_set = line_q[SET_W-1:0];
  assign fill_tag = line_q[LINE_W-1:SET_W];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vict;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] &&
          tag_q[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Oldest way by default; an invalid way (lowest index) overrides it.
  always_comb begin
    vict = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[set_idx][w] == WAY_W'(WAYS - 1))
        vict = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w])
        vict = WAY_W'(w);
    end
  end

  logic             touch_en;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    victim_d  = victim_q;
    line_d    = line_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    age_d     = age_q;
    data_d    = data_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    touch_en  = 1'b0;
    touch_set = set_idx;
    touch_way = hit_way;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            if (hit) begin
              data_d[set_idx][hit_way][off] = cpu_wdata;
              touch_en = 1'b1;
            end
            state_d = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_q[set_idx][hit_way][off];
            touch_en  = 1'b1;
          end else begin
            victim_d = vict;
            line_d   = cpu_addr[DW-1:OFF_W+2];
            beat_d   = '0;
            state_d  = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {line_q, beat_q, 2'b00};
        if (mem_ack) begin
          data_d[fill_set][victim_q][beat_q] = mem_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            valid_d[fill_set][victim_q] = 1'b1;
            tag_d[fill_set][victim_q]   = fill_tag;
            touch_en  = 1'b1;
            touch_set = fill_set;
            touch_way = victim_q;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = data_q[fill_set][victim_q][off];
        state_d   = IDLE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_addr & ~DW'(3);
        mem_wdata = cpu_wdata;
        if (mem_ack) begin
          cpu_ready = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          age_d[touch_set][w] = '0;
        else if (age_q[touch_set][w] <
                 age_q[touch_set][touch_way])
          age_d[touch_set][w] =
            age_q[touch_set][w] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      victim_q <= '0;
      line_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      line_q   <= line_d;
      valid_q  <= valid_d;
      age_q    <= age_d;
    end
  end

  // Tags and data need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache (4 sets, 2 ways, 4-word lines).
// Memory responder with programmable wait states and a transaction log.
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  set_assoc_cache #(
    .DATA_WIDTH(32), .SETS(4), .WAYS(2), .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] d;
  } exp_t;
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } tx_t;

  exp_t        sb[$];
  exp_t        mon_e;
  tx_t         log_q[$];
  logic [31:0] mem [int unsigned];

  int          wait_n = 0;
  int          wcnt = 0;
  int          stable_err = 0;
  int          req_cycles = 0;
  int          last_ack_cyc = 0;
  int          ready_cyc = 0;
  logic [31:0] last_addr = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h1000_0000 | a;
  endfunction

  // Memory responder: ack after wait_n wait cycles, decided at negedge.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      req_cycles++;
      if (wcnt > 0 && mem_addr !== last_addr) stable_err++;
      last_addr = mem_addr;
      if (wcnt >= wait_n) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 32'h0 : mem_rd(mem_addr);
        log_q.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_we) mem[mem_addr] = mem_wdata;
        wcnt = 0;
        last_ack_cyc = cyc;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: every cpu_ready pops one expected response.
  always @(negedge clk) begin
    #1;
    if (cpu_ready) begin
      ready_cyc = cyc;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: ready at addr %h", cpu_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_we", {31'b0, cpu_we}, {31'b0, mon_e.we});
        if (!mon_e.we) chk("sb_rdata", cpu_rdata, mon_e.d);
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed,
                        input int lat_exp, input string name);
    int lat;
    bit done;
    lat  = 0;
    done = 0;
    log_q.delete();
    req_cycles = 0;
    sb.push_back('{we, ed});
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    while (!done && lat < 200) begin
      @(negedge clk);
      #1;
      if (cpu_ready) done = 1;
      else lat++;
    end
    chk({name, "_lat"}, lat, lat_exp);
    if (!done) sb.delete();
    @(posedge clk);
    #1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic chk_refill(input logic [31:0] base,
                            input string name);
    chk({name, "_nbeats"}, log_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size())
        chk({name, "_beat_addr"},
            {log_q[i].a[31:1], log_q[i].we},
            base + 32'(4 * i));
    end
  endtask

  task automatic chk_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input string name);
    chk({name, "_nwr"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk({name, "_wr_we"}, {31'b0, log_q[0].we}, 1);
      chk({name, "_wr_addr"}, log_q[0].a, a);
      chk({name, "_wr_data"}, log_q[0].d, d);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem[32'h100] = 32'hA0;
    mem[32'h104] = 32'hA1;
    mem[32'h108] = 32'hA2;
    mem[32'h10C] = 32'hA3;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ctl", {29'b0, cpu_ready, mem_req, mem_we}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_maddr", mem_addr | mem_wdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_ctl", {29'b0, cpu_ready, mem_req, mem_we}, 0);
    chk("idle_bus", cpu_rdata | mem_addr | mem_wdata, 0);
    @(posedge clk);
    #1;

    // Cold miss then hit
    access(0, 32'h104, 0, 32'hA1, 5, "s1_miss");
    chk_refill(32'h100, "s1");
    access(0, 32'h10C, 0, 32'hA3, 0, "s1_hit");
    chk("s1_hit_noreq", req_cycles, 0);

    // Write hit updates the line and goes through
    access(1, 32'h104, 32'hDEADBEEF, 0, 1, "s3_wr");
    chk_write(32'h104, 32'hDEADBEEF, "s3");
    access(0, 32'h104, 0, 32'hDEADBEEF, 0, "s3_rd");
    chk("s3_rd_noreq", req_cycles, 0);

    // LRU eviction in set 0
    do_reset();
    access(0, 32'h000, 0, 32'h1000_0000, 5, "s2_a");
    access(0, 32'h040, 0, 32'h1000_0040, 5, "s2_b");
    access(0, 32'h000, 0, 32'h1000_0000, 0, "s2_a_hit");
    access(0, 32'h080, 0, 32'h1000_0080, 5, "s2_c");
    chk_refill(32'h080, "s2_c");
    access(0, 32'h000, 0, 32'h1000_0000, 0, "s2_a_hit2");
    chk("s2_a_noreq", req_cycles, 0);
    access(0, 32'h040, 0, 32'h1000_0040, 5, "s2_b_miss");
    chk_refill(32'h040, "s2_b");

    // Write miss does not allocate
    do_reset();
    access(1, 32'h200, 32'h12345678, 0, 1, "s4_wr");
    chk_write(32'h200, 32'h12345678, "s4");
    access(0, 32'h200, 0, 32'h12345678, 5, "s4_rd");
    chk_refill(32'h200, "s4");

    // Three wait cycles per beat
    wait_n = 3;
    stable_err = 0;
    access(0, 32'h020, 0, 32'h1000_0020, 17, "s5");
    chk_refill(32'h020, "s5");
    chk("s5_addr_stable", stable_err, 0);
    chk("s5_resp_gap", ready_cyc - last_ack_cyc, 1);
    wait_n = 0;

    // Reset during the second refill beat
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h300;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("s6_beat1_addr", mem_addr, 32'h304);
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    chk("s6_req_off", {31'b0, mem_req}, 0);
    reset = 1'b0;
    access(0, 32'h300, 0, 32'h1000_0300, 5, "s6_re");
    chk_refill(32'h300, "s6");

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
